// File: rtl/hazard_control_unit_pkg.sv
// Shared types for the hazard controller: FSM state, register id and the latch-control bundle.
package hazard_control_unit_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT, HALTED} hz_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  function automatic logic load_use_dep(input logic memread, input regbits_t rd,
                                        input regbits_t rs, input regbits_t rt);
    return memread && (rd != '0) && ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module hazard_control_unit_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: drives latch enables, bubbles and PC enable
// for load-use, redirect, I/D-cache misses and halt, plus stall/flush performance counters.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_redirect_i,
  input  logic             mem_ren_i,
  input  logic             mem_wen_i,
  input  logic             dhit_i,
  input  logic             ihit_i,
  input  logic             wb_halt_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             idex_en_o,
  output logic             exmem_en_o,
  output logic             memwb_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  hz_state_t state_q;
  hz_state_t state_d;
  hz_ctrl_t  ctrl;
  logic      halt_hit;
  logic      dmiss_hit;
  logic      lu_hit;
  logic      stall_inc;
  logic      flush_inc;

  // Priority decode; the load-use check is masked for the one cycle spent in LDSTALL.
  assign halt_hit  = (state_q == HALTED) || wb_halt_i;
  assign dmiss_hit = (mem_ren_i || mem_wen_i) && !dhit_i;
  assign lu_hit    = (state_q != LDSTALL) &&
                     load_use_dep(ex_memread_i, ex_rd_i, id_rs_i, id_rt_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RUN;
    if (halt_hit) begin
      state_d = HALTED;
    end else if (dmiss_hit) begin
      state_d = MEMWAIT;
    end else if (ex_redirect_i) begin
      state_d = RUN;
    end else if (lu_hit) begin
      state_d = LDSTALL;
    end
  end

  always_comb begin
    ctrl      = CTRL_RUN;
    halt_o    = 1'b0;
    flush_inc = 1'b0;
    if (rst_i) begin
      ctrl = CTRL_FREEZE;
    end else if (halt_hit) begin
      ctrl   = CTRL_FREEZE;
      halt_o = 1'b1;
    end else if (dmiss_hit) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_redirect_i) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
      flush_inc       = 1'b1;
    end else if (lu_hit) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_en    = 1'b0;
      ctrl.idex_flush = 1'b1;
    end else if (!ihit_i) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_flush = 1'b1;
    end
  end

  assign stall_inc = !ctrl.pc_en && !halt_o;

  assign pc_en_o      = ctrl.pc_en;
  assign ifid_en_o    = ctrl.ifid_en;
  assign idex_en_o    = ctrl.idex_en;
  assign exmem_en_o   = ctrl.exmem_en;
  assign memwb_en_o   = ctrl.memwb_en;
  assign ifid_flush_o = ctrl.ifid_flush;
  assign idex_flush_o = ctrl.idex_flush;

  hazard_control_unit_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .clr_i (1'b0),
    .cnt_o (stall_cnt_o)
  );

  hazard_control_unit_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .clr_i (1'b0),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: a reference model pushes expected outputs per cycle,
// and the sampler pops and compares them mid-cycle; directed counter checks follow each scenario.
module tb_hazard_control_unit;
  import hazard_control_unit_pkg::*;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef struct {
    logic [7:0]    ctl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic ex_memread, ex_redirect, mem_ren, mem_wen, dhit, ihit, wb_halt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  exp_t      sb_q[$];
  hz_state_t m_state;
  logic [CW-1:0] m_sc, m_fc;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .ex_redirect_i(ex_redirect),
    .mem_ren_i(mem_ren), .mem_wen_i(mem_wen), .dhit_i(dhit), .ihit_i(ihit),
    .wb_halt_i(wb_halt), .pc_en_o(pc_en), .ifid_en_o(ifid_en), .idex_en_o(idex_en),
    .exmem_en_o(exmem_en), .memwb_en_o(memwb_en), .ifid_flush_o(ifid_flush),
    .idex_flush_o(idex_flush), .halt_o(halt), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    else n_pass++;
  endtask

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0; ex_redirect = 1'b0;
    mem_ren = 1'b0; mem_wen = 1'b0; dhit = 1'b1; ihit = 1'b1; wb_halt = 1'b0;
  endtask

  // One clock: model this cycle, push expectation, sample at negedge, advance model at the edge.
  task automatic step();
    exp_t e, g;
    hz_state_t nxt;
    logic sinc, finc, dep;
    sinc = 1'b0; finc = 1'b0; nxt = RUN;
    dep  = ex_memread && ex_rd != 5'd0 && (ex_rd == id_rs || ex_rd == id_rt);
    if (rst) begin
      m_sc = '0; m_fc = '0;
      e.ctl = 8'b0000_0000;
    end else if (m_state == HALTED || wb_halt) begin
      e.ctl = 8'b0000_0001; nxt = HALTED;
    end else if ((mem_ren || mem_wen) && !dhit) begin
      e.ctl = 8'b0000_0000; nxt = MEMWAIT; sinc = 1'b1;
    end else if (ex_redirect) begin
      e.ctl = 8'b1111_1110; finc = 1'b1;
    end else if (m_state != LDSTALL && dep) begin
      e.ctl = 8'b0011_1010; nxt = LDSTALL; sinc = 1'b1;
    end else if (!ihit) begin
      e.ctl = 8'b0111_1100; sinc = 1'b1;
    end else begin
      e.ctl = 8'b1111_1000;
    end
    e.sc = m_sc; e.fc = m_fc;
    sb_q.push_back(e);

    @(negedge clk);
    g = sb_q.pop_front();
    check("ctl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt}, g.ctl);
    check("stall_cnt", stall_cnt, g.sc);
    check("flush_cnt", flush_cnt, g.fc);
    $display("cyc %0d rst=%b ctl=%b stall=%0d flush=%0d", cyc, rst,
             {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt},
             stall_cnt, flush_cnt);

    if (rst) begin
      m_state = RUN;
    end else begin
      m_state = nxt;
      if (sinc && m_sc != CMAX) m_sc = m_sc + 1'b1;
      if (finc && m_fc != CMAX) m_fc = m_fc + 1'b1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1; step(); step();
    rst = 1'b0;
  endtask

  initial begin
    m_state = RUN; m_sc = '0; m_fc = '0;
    set_idle();
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: reset, then normal run, then reset asserted mid-stall
    do_reset();
    repeat (3) step();
    ihit = 1'b0; step(); step();
    rst = 1'b1; step();
    check("rst_halt", halt, 1'b0);
    check("rst_stall_cnt", stall_cnt, '0);
    rst = 1'b0; ihit = 1'b1; step();
    check("post_rst_pc_en", pc_en, 1'b1);

    // 2: load-use gives exactly one bubble
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_rs = 5'd1;
    step(); step();
    check("lu_stall_cnt", stall_cnt, 4'd1);
    set_idle(); step();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rt = 5'd0; id_rs = 5'd0;
    step(); step();
    check("r0_no_stall", stall_cnt, 4'd1);

    // 3: D-miss freeze for three cycles
    do_reset();
    mem_ren = 1'b1; dhit = 1'b0;
    repeat (3) step();
    dhit = 1'b1; step();
    check("dmiss_stall_cnt", stall_cnt, 4'd3);
    mem_wen = 1'b1; mem_ren = 1'b0; dhit = 1'b0; step();
    dhit = 1'b1; step();

    // 4: redirect beats load-use
    do_reset();
    ex_redirect = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7; id_rs = 5'd7;
    step();
    ex_redirect = 1'b0; ex_memread = 1'b0; step();
    check("redir_flush_cnt", flush_cnt, 4'd1);
    check("redir_no_bubble", stall_cnt, 4'd0);

    // 5: I-miss for two cycles, then redirect combined with D-miss and with I-miss
    do_reset();
    ihit = 1'b0; step(); step();
    ihit = 1'b1; step();
    ex_redirect = 1'b1; mem_ren = 1'b1; dhit = 1'b0; step();
    dhit = 1'b1; step();
    mem_ren = 1'b0; ihit = 1'b0; step();
    set_idle(); step();

    // 6: halt is sticky until reset
    do_reset();
    wb_halt = 1'b1; step();
    wb_halt = 1'b0; ihit = 1'b0; ex_redirect = 1'b1;
    repeat (4) step();
    check("halt_sticky", halt, 1'b1);
    set_idle();

    // counters saturate without wrapping
    do_reset();
    ihit = 1'b0; repeat (CMAX + 4) step();
    check("stall_sat", stall_cnt, CMAX);
    ihit = 1'b1; ex_redirect = 1'b1; repeat (CMAX + 4) step();
    check("flush_sat", flush_cnt, CMAX);

    // randomized mix with narrow register space to provoke dependencies
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_memread  = ($urandom_range(0, 1) == 1);
      ex_redirect = ($urandom_range(0, 5) == 0);
      mem_ren     = ($urandom_range(0, 3) == 0);
      mem_wen     = ($urandom_range(0, 5) == 0);
      dhit        = ($urandom_range(0, 2) != 0);
      ihit        = ($urandom_range(0, 3) != 0);
      wb_halt     = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
